// File: rtl/debounce_pkg.sv
// Shared constants and types for the multi-channel hysteretic debouncer.
// Imported by debounce_chan and debounce_hyst.
package debounce_pkg;

    localparam int DB_SYNC_MIN  = 2;
    localparam int DB_SYNC_MAX  = 4;
    localparam int DB_CNT_WIDTH = 21;

    typedef struct packed {
        logic [DB_CNT_WIDTH-1:0] cnt;
        logic                    out;
    } db_state_t;

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser chain, qualification counter,
// and registered rise/fall strobes.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   P_CNT_WIDTH   = DB_CNT_WIDTH,
    parameter int   P_SYNC_STAGES = 2,
    parameter logic P_RST_VAL     = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din,
    input  logic [P_CNT_WIDTH-1:0] rise_clks,
    input  logic [P_CNT_WIDTH-1:0] fall_clks,
    input  logic                   bypass,
    output logic                   dout,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic                   pending
);

    localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [P_SYNC_STAGES-1:0] sync_q, sync_d;
    logic [P_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                     out_q, out_d;
    logic                     rise_q, rise_d;
    logic                     fall_q, fall_d;
    logic                     s;
    logic [P_CNT_WIDTH-1:0]   n;
    logic [P_CNT_WIDTH-1:0]   n_m1;

    always_comb begin
        s      = sync_q[P_SYNC_STAGES-1];
        sync_d = {sync_q[P_SYNC_STAGES-2:0], din};
        n      = s ? rise_clks : fall_clks;
        // A zero threshold behaves like one: the change lands on the first edge.
        n_m1   = (n == '0) ? '0 : n - CNT_ONE;
        cnt_d  = cnt_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (bypass) begin
            cnt_d = '0;
            if (s != out_q) begin
                out_d  = s;
                rise_d = s;
                fall_d = ~s;
            end
        end else if (s == out_q) begin
            cnt_d = '0;
        end else if (cnt_q >= n_m1) begin
            out_d  = s;
            cnt_d  = '0;
            rise_d = s;
            fall_d = ~s;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {P_SYNC_STAGES{P_RST_VAL}};
            cnt_q  <= '0;
            out_q  <= P_RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout       = out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign pending    = sync_q[P_SYNC_STAGES-1] ^ out_q;

endmodule

// File: rtl/debounce_hyst.sv
// Multi-channel debouncer with separate rise/fall thresholds, event
// strobes, pending flags and a bypass path.
module debounce_hyst
    import debounce_pkg::*;
#(
    parameter int               P_WIDTH       = 8,
    parameter int               P_CNT_WIDTH   = DB_CNT_WIDTH,
    parameter int               P_SYNC_STAGES = 2,
    parameter logic [P_WIDTH-1:0] P_RST_VAL   = '0
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic [P_WIDTH-1:0]     DATA_IN,
    input  logic [P_CNT_WIDTH-1:0] RISE_CLKS,
    input  logic [P_CNT_WIDTH-1:0] FALL_CLKS,
    input  logic                   BYPASS,
    output logic [P_WIDTH-1:0]     DATA_OUT,
    output logic [P_WIDTH-1:0]     RISE_PULSE,
    output logic [P_WIDTH-1:0]     FALL_PULSE,
    output logic [P_WIDTH-1:0]     PENDING
);

    if (P_SYNC_STAGES < DB_SYNC_MIN || P_SYNC_STAGES > DB_SYNC_MAX) begin : g_bad_sync
        $error("debounce_hyst: P_SYNC_STAGES must be 2..4");
    end

    for (genvar i = 0; i < P_WIDTH; i++) begin : g_chan
        debounce_chan #(
            .P_CNT_WIDTH   (P_CNT_WIDTH),
            .P_SYNC_STAGES (P_SYNC_STAGES),
            .P_RST_VAL     (P_RST_VAL[i])
        ) u_chan (
            .clk        (CLOCK),
            .rst        (RESET),
            .din        (DATA_IN[i]),
            .rise_clks  (RISE_CLKS),
            .fall_clks  (FALL_CLKS),
            .bypass     (BYPASS),
            .dout       (DATA_OUT[i]),
            .rise_pulse (RISE_PULSE[i]),
            .fall_pulse (FALL_PULSE[i]),
            .pending    (PENDING[i])
        );
    end

endmodule
